// File: rtl/gemm_pkg.sv
// gemm_pkg: FSM states, accelerator register map and control/dimension field positions for the GEMM tile dispatcher
package gemm_pkg;
  typedef enum logic [2:0] {IDLE, POLL, WRITE, NEXT, DONE} state_t;
  localparam logic [4:0] OFS_A = 5'd0, OFS_B = 5'd4, OFS_C = 5'd8, OFS_A_STRIDE = 5'd12,
                         OFS_B_STRIDE = 5'd16, OFS_CTRL = 5'd20, OFS_DIM = 5'd24;
  localparam int CTRL_STORE = 0, CTRL_OVERWRITE = 1;
  localparam int DIM_M_LSB = 0, DIM_K_LSB = 5, DIM_N_LSB = 10;
  localparam int WRITE_BEATS = 7;
  function automatic logic [4:0] reg_ofs(input logic [2:0] beat);
    return beat == 3'd0 ? OFS_A : beat == 3'd1 ? OFS_B : beat == 3'd2 ? OFS_C :
           beat == 3'd3 ? OFS_A_STRIDE : beat == 3'd4 ? OFS_B_STRIDE : beat == 3'd5 ? OFS_CTRL : OFS_DIM;
  endfunction
  // stride * tile edge as a shift-and-add, so tile stepping never needs a multiplier
  function automatic logic [31:0] tile_scale(input logic [31:0] x, input logic [4:0] t);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 5; i++) acc = acc + (t[i] ? x << i : 32'd0);
    return acc;
  endfunction
endpackage

// File: rtl/gemm_tile_dispatcher_if.sv
// gemm_tile_dispatcher_if: accelerator system bus; read data returns in the same cycle as the read request
interface gemm_tile_dispatcher_if;
  logic en, rdwr;
  logic [31:0] addr, wr_data, rd_data;
  modport master(output en, rdwr, addr, wr_data, input rd_data);
  modport slave(input en, rdwr, addr, wr_data, output rd_data);
endinterface

// File: rtl/gemm_tile_counter.sv
// gemm_tile_counter: tile origin, clipped tile size and last-tile flag for one matrix dimension
module gemm_tile_counter #(
  parameter int unsigned TILE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        step,
  input  logic [15:0] dim,
  output logic [15:0] origin,
  output logic [4:0]  size,
  output logic        last
);
  logic [15:0] rem;
  always_comb begin
    rem = dim - origin;
    last = rem <= 16'(TILE);
    size = last ? rem[4:0] : 5'(TILE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) origin <= '0;
    else if (clr || (step && last)) origin <= '0;
    else if (step) origin <= origin + 16'(TILE);
endmodule

// File: rtl/gemm_tile_dispatcher.sv
// gemm_tile_dispatcher: walks a GEMM job tile by tile (m outer, n, k inner) and programs each tile into the accelerator.
// Defining GEMM_DISPATCH_PERF_EN adds a saturating count of busy poll cycles on poll_stall_cycles.
module gemm_tile_dispatcher
  import gemm_pkg::*;
#(
  parameter int unsigned TILE         = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h9000_0000,
  parameter int unsigned C_TILE_BYTES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [31:0]                   a_base,
  input  logic [31:0]                   b_base,
  input  logic [31:0]                   c_base,
  input  logic [31:0]                   a_stride,
  input  logic [31:0]                   b_stride,
  input  logic [15:0]                   m_dim,
  input  logic [15:0]                   k_dim,
  input  logic [15:0]                   n_dim,
  gemm_tile_dispatcher_if.master        system_bus,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   poll_stall_cycles
);
  state_t state;
  logic [2:0] beat, beat_n;
  logic [15:0] m_q, k_q, n_q, k0, n0;
  logic [4:0] msize, ksize, nsize;
  logic m_last, k_last, n_last, accept, nx;
  logic [31:0] a_stride_q, b_stride_q, a_step, b_step, b_base_q, a_row, b_row, c_addr;
  logic [31:0] ctrl_word, dim_word, next_data, next_addr;
  assign accept = state == IDLE && start;
  assign nx = state == NEXT;
  gemm_tile_counter #(.TILE(TILE)) u_m (.clk(clk), .rst(rst), .clr(accept), .step(nx && k_last && n_last),
                                        .dim(m_q), .origin(), .size(msize), .last(m_last));
  gemm_tile_counter #(.TILE(TILE)) u_n (.clk(clk), .rst(rst), .clr(accept), .step(nx && k_last),
                                        .dim(n_q), .origin(n0), .size(nsize), .last(n_last));
  gemm_tile_counter #(.TILE(TILE)) u_k (.clk(clk), .rst(rst), .clr(accept), .step(nx),
                                        .dim(k_q), .origin(k0), .size(ksize), .last(k_last));
  // a_row tracks a_base+m0*a_stride, b_row tracks b_base+k0*b_stride, c_addr tracks the linear C tile slot
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {m_q, k_q, n_q} <= '0;
      {a_stride_q, b_stride_q, a_step, b_step, b_base_q, a_row, b_row, c_addr} <= '0;
    end else if (accept) begin
      {m_q, k_q, n_q} <= {m_dim, k_dim, n_dim};
      a_stride_q <= a_stride;
      b_stride_q <= b_stride;
      a_step <= tile_scale(a_stride, 5'(TILE));
      b_step <= tile_scale(b_stride, 5'(TILE));
      b_base_q <= b_base;
      a_row <= a_base;
      b_row <= b_base;
      c_addr <= c_base;
    end else if (nx) begin
      b_row <= k_last ? b_base_q : b_row + b_step;
      c_addr <= k_last ? c_addr + 32'(C_TILE_BYTES) : c_addr;
      a_row <= k_last && n_last ? a_row + a_step : a_row;
    end
  always_comb begin
    beat_n = state == POLL ? 3'd0 : beat + 3'd1;
    ctrl_word = '0;
    ctrl_word[CTRL_STORE] = k_last;
    ctrl_word[CTRL_OVERWRITE] = k0 == '0;
    dim_word = '0;
    dim_word[DIM_M_LSB +: 5] = msize;
    dim_word[DIM_K_LSB +: 5] = ksize;
    dim_word[DIM_N_LSB +: 5] = nsize;
    next_data = beat_n == 3'd0 ? a_row + {16'b0, k0} : beat_n == 3'd1 ? b_row + {16'b0, n0} :
                beat_n == 3'd2 ? c_addr : beat_n == 3'd3 ? a_stride_q : beat_n == 3'd4 ? b_stride_q :
                beat_n == 3'd5 ? ctrl_word : dim_word;
    next_addr = BASE_ADDR + {27'b0, reg_ofs(beat_n)};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      beat <= '0;
      {busy, done, err} <= '0;
      {system_bus.en, system_bus.rdwr} <= '0;
      system_bus.addr <= '0;
      system_bus.wr_data <= '0;
    end else begin
      {done, err} <= '0;
      {system_bus.en, system_bus.rdwr} <= '0;
      system_bus.addr <= '0;
      system_bus.wr_data <= '0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (~|m_dim || ~|k_dim || ~|n_dim) begin
            state <= DONE;
            {done, err} <= 2'b11;
          end else begin
            state <= POLL;
            system_bus.en <= 1'b1;
            system_bus.addr <= BASE_ADDR;
          end
        end
        POLL: if (system_bus.rd_data[0]) begin
          system_bus.en <= 1'b1;
          system_bus.addr <= BASE_ADDR;
        end else begin
          state <= WRITE;
          beat <= '0;
          {system_bus.en, system_bus.rdwr} <= 2'b11;
          system_bus.addr <= next_addr;
          system_bus.wr_data <= next_data;
        end
        WRITE: if (beat == 3'(WRITE_BEATS - 1)) state <= NEXT;
        else begin
          beat <= beat_n;
          {system_bus.en, system_bus.rdwr} <= 2'b11;
          system_bus.addr <= next_addr;
          system_bus.wr_data <= next_data;
        end
        NEXT: if (m_last && n_last && k_last) begin
          state <= DONE;
          done <= 1'b1;
        end else begin
          state <= POLL;
          system_bus.en <= 1'b1;
          system_bus.addr <= BASE_ADDR;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef GEMM_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) poll_stall_cycles <= '0;
    else if (accept) poll_stall_cycles <= '0;
    else if (state == POLL && system_bus.rd_data[0] && ~&poll_stall_cycles) poll_stall_cycles <= poll_stall_cycles + 32'd1;
`else
  assign poll_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_gemm_tile_dispatcher.sv
// tb_gemm_tile_dispatcher: directed and random GEMM jobs scoreboarded against a plain loop-nest model of the tile walk
module tb_gemm_tile_dispatcher;
  localparam int T = 16;
  localparam logic [31:0] BASE = 32'h9000_0000;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] a_base = '0, b_base = '0, c_base = '0, a_stride = '0, b_stride = '0;
  logic [15:0] m_dim = '0, k_dim = '0, n_dim = '0;
  logic busy, done, err;
  logic [31:0] poll_stall_cycles;
  gemm_tile_dispatcher_if system_bus();
  gemm_tile_dispatcher dut (
    .clk(clk), .rst(rst), .start(start), .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .a_stride(a_stride), .b_stride(b_stride), .m_dim(m_dim), .k_dim(k_dim), .n_dim(n_dim),
    .system_bus(system_bus), .busy(busy), .done(done), .err(err), .poll_stall_cycles(poll_stall_cycles)
  );
  always #5 clk = ~clk;

  typedef struct {bit wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  typedef struct {bit err; int stalls;} fin_t;
  txn_t bus_q[$];
  fin_t fin_q[$];
  int plan[64];
  int tile_i, poll_i;
  int checks = 0, fails = 0, wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // accelerator model: the poll of tile t reads busy for plan[t] cycles, then idle
  assign system_bus.rd_data = {31'b0, tile_i < 64 ? poll_i < plan[tile_i] : 1'b0};
  always @(posedge clk or negedge rst)
    if (!rst) begin
      tile_i <= 0;
      poll_i <= 0;
    end else if (start && !busy) begin
      tile_i <= 0;
      poll_i <= 0;
    end else if (system_bus.en && !system_bus.rdwr) begin
      if (system_bus.rd_data[0]) poll_i <= poll_i + 1;
      else begin
        poll_i <= 0;
        tile_i <= tile_i + 1;
      end
    end

  always @(negedge clk) begin : monitor
    txn_t e;
    fin_t f;
    if (system_bus.en) begin
      if (bus_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_bus: got addr %h rdwr %0d expected no bus cycle", system_bus.addr, system_bus.rdwr);
      end else begin
        e = bus_q.pop_front();
        chk("bus_rdwr", 32'(system_bus.rdwr), 32'(e.wr));
        chk("bus_addr", system_bus.addr, e.addr);
        if (e.wr) begin
          chk("bus_wr_data", system_bus.wr_data, e.data);
          wr_seen++;
        end
      end
    end else begin
      chk("idle_addr", system_bus.addr, 32'h0);
      chk("idle_wr_data", system_bus.wr_data, 32'h0);
    end
    if (done) begin
      if (fin_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        f = fin_q.pop_front();
        chk("err", 32'(err), 32'(f.err));
        chk("pending_bus_at_done", 32'(bus_q.size()), 32'h0);
`ifdef GEMM_DISPATCH_PERF_EN
        chk("poll_stall_cycles", poll_stall_cycles, 32'(f.stalls));
`else
        chk("poll_stall_cycles", poll_stall_cycles, 32'h0);
`endif
      end
    end else if (err) chk("err_without_done", 32'(err), 32'h0);
  end

  // reference: nested tile loops with direct multiply arithmetic
  task automatic expect_job();
    int mm, kk, nn, nt, tile, total;
    logic [31:0] w[7];
    mm = int'(m_dim);
    kk = int'(k_dim);
    nn = int'(n_dim);
    tile = 0;
    total = 0;
    if (mm == 0 || kk == 0 || nn == 0) begin
      fin_q.push_back('{1'b1, 0});
      return;
    end
    nt = (nn + T - 1) / T;
    for (int m0 = 0; m0 < mm; m0 += T)
      for (int n0 = 0; n0 < nn; n0 += T)
        for (int k0 = 0; k0 < kk; k0 += T) begin
          int ms, ks, ns;
          ms = mm - m0 < T ? mm - m0 : T;
          ks = kk - k0 < T ? kk - k0 : T;
          ns = nn - n0 < T ? nn - n0 : T;
          for (int s = 0; s <= plan[tile]; s++) bus_q.push_back('{1'b0, BASE, 32'h0});
          total += plan[tile];
          w[0] = a_base + 32'(m0) * a_stride + 32'(k0);
          w[1] = b_base + 32'(k0) * b_stride + 32'(n0);
          w[2] = c_base + 32'(((m0 / T) * nt + n0 / T) * 1024);
          w[3] = a_stride;
          w[4] = b_stride;
          w[5] = {30'b0, k0 == 0, k0 + T >= kk};
          w[6] = 32'(ns * 1024 + ks * 32 + ms);
          for (int i = 0; i < 7; i++) bus_q.push_back('{1'b1, BASE + 32'(4 * i), w[i]});
          tile++;
        end
    fin_q.push_back('{1'b0, total});
  endtask

  // returns cycles from the first busy cycle to the done cycle
  task automatic run(input bit poke, output int lat);
    expect_job();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 3) begin
        start = 1'b1;
        a_base = ~a_base;
        m_dim = 16'd1;
      end
      if (poke && lat == 4) start = 1'b0;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
      bus_q.delete();
      fin_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_job(input int m, input int k, input int n);
    m_dim = 16'(m);
    k_dim = 16'(k);
    n_dim = 16'(n);
    a_base = $urandom;
    b_base = $urandom;
    c_base = $urandom;
    a_stride = $urandom;
    b_stride = $urandom;
    for (int i = 0; i < 64; i++) plan[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0;
    #12;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_en", 32'(system_bus.en), 32'h0);
    chk("reset_poll_stall", poll_stall_cycles, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_job(16, 16, 16);
    run(1'b0, lat);
    chk("single_tile_done_latency", 32'(lat), 32'd9);
    set_job(16, 32, 16);
    run(1'b0, lat);
    set_job(20, 16, 16);
    run(1'b0, lat);
    set_job(16, 16, 16);
    plan[0] = 5;
    run(1'b0, lat);
    chk("stalled_done_latency", 32'(lat), 32'd14);
    set_job(16, 0, 16);
    run(1'b0, lat);
    chk("zero_dim_done_latency", 32'(lat), 32'h0);
    set_job(40, 24, 33);
    run(1'b1, lat);
    set_job(16, 16, 16);
    expect_job();
    w0 = wr_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && wr_seen < w0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("reset_mid_job_en", 32'(system_bus.en), 32'h0);
    chk("reset_mid_job_busy", 32'(busy), 32'h0);
    bus_q.delete();
    fin_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(1'b0, lat);
    for (int j = 0; j < 20; j++) begin
      set_job($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40));
      if ($urandom_range(0, 9) == 0) k_dim = 16'h0;
      if ($urandom_range(0, 11) == 0) m_dim = 16'h0;
      for (int i = 0; i < 64; i++) plan[i] = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      run(j == 7, lat);
    end
    chk("final_idle", 32'(busy), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/gemm_tile_dispatcher.md
GEMM_TILE_DISPATCHER -- requirements
Module: gemm_tile_dispatcher

Interface
REQ-001 Parameter TILE, default 16, maximum tile edge in elements (1..31).
REQ-002 Parameter BASE_ADDR, default 32'h9000_0000, accelerator register base.
REQ-003 Parameter C_TILE_BYTES, default 1024, byte spacing between consecutive C tiles.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle job request; ignored while busy=1.
REQ-007 a_base, b_base, c_base  input  32 each  matrix base byte addresses.
REQ-008 a_stride, b_stride  input  32 each  row strides in bytes (1-byte elements).
REQ-009 m_dim, k_dim, n_dim  input  16 each  full matrix dimensions in elements.
REQ-010 system_bus_en, system_bus_rdwr  output  1 each  bus request; rdwr=1 write, 0 read.
REQ-011 system_bus_addr, system_bus_wr_data  output  32 each  bus address and write data.
REQ-012 system_bus_rd_data  input  32  read data, valid in the same cycle as the read request.
REQ-013 busy, done, err  output  1 each  job active; one-cycle completion pulse; one-cycle error pulse coincident with done.
REQ-014 poll_stall_cycles  output  32  back-pressure counter (see Configuration).

Function
REQ-015 start with busy=0 SHALL latch all job inputs; the following cycle SHALL be busy=1.
REQ-016 Tile loop order SHALL be m outer, n middle, k inner; tile origins m0, n0, k0 step by TILE.
REQ-017 Tile sizes SHALL be msize=min(TILE, m_dim-m0), and likewise ksize and nsize.
REQ-018 FSM states SHALL be IDLE, POLL, WRITE, NEXT, DONE.
REQ-019 POLL SHALL drive en=1, rdwr=0, addr=BASE_ADDR; rd_data[0]=1 stays in POLL, 0 goes to WRITE.
REQ-020 WRITE SHALL issue 7 consecutive single-cycle writes (en=1, rdwr=1) to BASE_ADDR+0,4,8,12,16,20,24.
REQ-021 The write data in that order SHALL be: A addr, B addr, C addr, a_stride, b_stride, control, dimension.
REQ-022 A addr SHALL equal a_base+m0*a_stride+k0, and B addr SHALL equal b_base+k0*b_stride+n0, both modulo 2^32.
REQ-023 C addr SHALL equal c_base+(m_tile_idx*n_tiles+n_tile_idx)*C_TILE_BYTES.
REQ-024 Tile addresses SHALL be produced by incremental adders, not multipliers.
REQ-025 Control word SHALL be {30'b0, overwrite, store}, with overwrite=1 when k0=0 and store=1 when on the last k tile.
REQ-026 Dimension word SHALL be {17'b0, nsize[4:0], ksize[4:0], msize[4:0]}, and SHALL always be the final write of a tile.
REQ-027 NEXT SHALL advance the tile indices in one cycle, then go to POLL, or to DONE after the last tile.
REQ-028 DONE SHALL pulse done for one cycle, then return to IDLE with busy=0.
REQ-029 Minimum cost per tile SHALL be 1 poll + 7 writes + 1 NEXT = 9 cycles.
REQ-030 A start with any dimension equal to 0 SHALL give done=1 and err=1 in the next cycle, with no bus activity.
REQ-031 Outside POLL and WRITE, system_bus_en SHALL be 0 and the address and data outputs SHALL be 0.

Reset
REQ-032 While rst=0: FSM=IDLE, and all outputs and counters are 0, taking effect immediately (asynchronous).
REQ-033 Reset mid-job SHALL abandon the job; the next start SHALL begin from tile (0,0,0).

Configuration
REQ-034 With macro GEMM_DISPATCH_PERF_EN defined, poll_stall_cycles SHALL increment each POLL cycle with rd_data[0]=1, saturate at all-ones, and clear on an accepted start.
REQ-035 Without GEMM_DISPATCH_PERF_EN, poll_stall_cycles SHALL be tied to 0 and no counter logic is generated.

Structure
REQ-036 Package gemm_pkg SHALL hold the FSM state enum, register offset constants (0..24), and the control/dimension bit-field positions.
REQ-037 A sub-module gemm_tile_counter (index, origin, size and last flag for one dimension) SHALL be instantiated three times.

Verification
REQ-038 M=K=N=16, rd_data=0: 1 poll then 7 writes at 9000_0000..9000_0018; control=3, dim=0x4210; done on the 9th cycle after busy rises.
REQ-039 M=16, K=32, N=16: two tiles with control 2 then 1; second tile A addr=a_base+16, B addr=b_base+16*b_stride.
REQ-040 M=20, K=N=16: second tile dim=0x4204 and C addr=c_base+1024.
REQ-041 rd_data[0]=1 for 5 polls, then 0: no writes during stall; with the macro, poll_stall_cycles=5.
REQ-042 k_dim=0: done=1 and err=1 one cycle after start, with en never asserted.
REQ-043 rst=0 during the 3rd write beat: en drops immediately and busy=0; a restart reissues tile 0 from its first write (A addr).
